reg_file_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute/writeback controller sitting directly upstream of the 4x16-bit register file.
- Fetches 16-bit instructions over a request/valid handshake and drives the register file's read_en/read_adr1/read_adr2 and write_en/write_adr/write_data.
- Contains the integer ALU, the PC and branch logic; it is the sole writer of the register file.

---
 rtl/reg_file_sequencer_if.sv | 34 +++
 rtl/reg_file_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_reg_file_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sequencer_if.sv
// Bus bundle between the sequencer and its environment: the instruction
// fetch handshake plus the read/write ports of the 4x16 register file.
interface reg_file_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int PC_WIDTH   = 8
) ();
  logic                  instr_req;
  logic [PC_WIDTH-1:0]   instr_addr;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_adr1;
  logic [ADDR_WIDTH-1:0] read_adr2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_adr;
  logic [DATA_WIDTH-1:0] write_data;

  // The sequencer drives requests, addresses and writeback data
  modport master (
    output instr_req, instr_addr, read_en, read_adr1, read_adr2,
           write_en, write_adr, write_data,
    input  instr_valid, instr_data, read_data1, read_data2
  );

  // Instruction memory and register file answer the sequencer
  modport slave (
    input  instr_req, instr_addr, read_en, read_adr1, read_adr2,
           write_en, write_adr, write_data,
    output instr_valid, instr_data, read_data1, read_data2
  );
endinterface

// File: rtl/reg_file_sequencer.sv
// Fetch/decode/execute/writeback controller in front of the 4x16 register
// file. Owns the PC, branch logic and integer ALU, and is the only writer
// of the register file.
module reg_file_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int PC_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  reg_file_sequencer_if.master bus,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 zero_flag,
  output logic                 halted,
  output logic                 illegal_op
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t                state_r;
  state_t                next_state_s;
  logic [15:0]           ir_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic [PC_WIDTH-1:0]   pc_r;
  logic                  zero_r;
  logic                  illegal_r;

  logic [3:0]            opcode_s;
  logic [ADDR_WIDTH-1:0] rd_s;
  logic [ADDR_WIDTH-1:0] rs1_s;
  logic [ADDR_WIDTH-1:0] rs2_s;
  logic [7:0]            imm8_s;
  logic [PC_WIDTH-1:0]   pc_plus1_s;
  logic [PC_WIDTH-1:0]   exec_pc_s;
  logic [DATA_WIDTH-1:0] alu_result_s;
  logic                  writes_reg_s;
  logic                  updates_zero_s;
  logic                  illegal_s;
  logic                  is_halt_s;
  logic                  fetch_fire_s;

  // Instruction fields; register indices are narrowed/widened to ADDR_WIDTH
  assign opcode_s   = ir_r[15:12];
  assign rd_s       = ADDR_WIDTH'(ir_r[11:10]);
  assign rs1_s      = ADDR_WIDTH'(ir_r[9:8]);
  assign rs2_s      = ADDR_WIDTH'(ir_r[7:6]);
  assign imm8_s     = ir_r[7:0];
  assign pc_plus1_s = pc_r + PC_WIDTH'(1);

  // A fetch completes only when a request is actually issued and answered
  assign fetch_fire_s = run & bus.instr_valid;

  assign pc         = pc_r;
  assign zero_flag  = zero_r;
  assign illegal_op = illegal_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (fetch_fire_s) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE:  next_state_s = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_halt_s) begin
          next_state_s = ST_HALT;
        end else if (writes_reg_s) begin
          next_state_s = ST_WRITEBACK;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_WRITEBACK: next_state_s = ST_FETCH;
      ST_HALT:      next_state_s = ST_HALT;
      default:      next_state_s = ST_FETCH;
    endcase
  end

  // ALU and branch resolution on the operands returned by the register file
  always_comb begin
    alu_result_s   = {DATA_WIDTH{1'b0}};
    writes_reg_s   = 1'b0;
    updates_zero_s = 1'b0;
    illegal_s      = 1'b0;
    is_halt_s      = 1'b0;
    exec_pc_s      = pc_plus1_s;
    case (opcode_s)
      OP_NOP: exec_pc_s = pc_plus1_s;
      OP_ADD: begin
        alu_result_s   = bus.read_data1 + bus.read_data2;
        writes_reg_s   = 1'b1;
        updates_zero_s = 1'b1;
      end
      OP_SUB: begin
        alu_result_s   = bus.read_data1 - bus.read_data2;
        writes_reg_s   = 1'b1;
        updates_zero_s = 1'b1;
      end
      OP_AND: begin
        alu_result_s   = bus.read_data1 & bus.read_data2;
        writes_reg_s   = 1'b1;
        updates_zero_s = 1'b1;
      end
      OP_OR: begin
        alu_result_s   = bus.read_data1 | bus.read_data2;
        writes_reg_s   = 1'b1;
        updates_zero_s = 1'b1;
      end
      OP_XOR: begin
        alu_result_s   = bus.read_data1 ^ bus.read_data2;
        writes_reg_s   = 1'b1;
        updates_zero_s = 1'b1;
      end
      OP_LDI: begin
        alu_result_s   = DATA_WIDTH'(imm8_s);
        writes_reg_s   = 1'b1;
        updates_zero_s = 1'b1;
      end
      OP_MOV: begin
        alu_result_s   = bus.read_data1;
        writes_reg_s   = 1'b1;
        updates_zero_s = 1'b1;
      end
      OP_JMP: exec_pc_s = PC_WIDTH'(imm8_s);
      OP_BEQZ: begin
        if (bus.read_data1 == {DATA_WIDTH{1'b0}}) begin
          exec_pc_s = PC_WIDTH'(imm8_s);
        end else begin
          exec_pc_s = pc_plus1_s;
        end
      end
      OP_HALT: is_halt_s = 1'b1;
      // Opcodes A-E behave as NOP but are flagged
      default: illegal_s = 1'b1;
    endcase
  end

  // Architectural state: instruction capture, result latch, flags and PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_r      <= 16'h0000;
      result_r  <= {DATA_WIDTH{1'b0}};
      pc_r      <= {PC_WIDTH{1'b0}};
      zero_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (fetch_fire_s) begin
            ir_r <= bus.instr_data[15:0];
          end
        end
        ST_EXECUTE: begin
          if (writes_reg_s) begin
            result_r <= alu_result_s;
          end
          if (updates_zero_s) begin
            zero_r <= (alu_result_s == {DATA_WIDTH{1'b0}});
          end
          if (illegal_s) begin
            illegal_r <= 1'b1;
          end
          // Register writers advance the PC in WRITEBACK; HALT freezes it
          if (!writes_reg_s && !is_halt_s) begin
            pc_r <= exec_pc_s;
          end
        end
        ST_WRITEBACK: pc_r <= pc_plus1_s;
        default: ;
      endcase
    end
  end

  // Bus outputs decoded from the current state; enables are one-state pulses
  always_comb begin
    bus.instr_req  = 1'b0;
    bus.instr_addr = pc_r;
    bus.read_en    = 1'b0;
    bus.read_adr1  = {ADDR_WIDTH{1'b0}};
    bus.read_adr2  = {ADDR_WIDTH{1'b0}};
    bus.write_en   = 1'b0;
    bus.write_adr  = {ADDR_WIDTH{1'b0}};
    bus.write_data = {DATA_WIDTH{1'b0}};
    halted         = 1'b0;
    case (state_r)
      // No request while reset is held, even though the state reads FETCH
      ST_FETCH: bus.instr_req = run & reset;
      ST_DECODE: begin
        bus.read_en   = 1'b1;
        bus.read_adr1 = rs1_s;
        bus.read_adr2 = rs2_s;
      end
      ST_WRITEBACK: begin
        bus.write_en   = 1'b1;
        bus.write_adr  = rd_s;
        bus.write_data = result_r;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer: an instruction memory and register
// file surround the DUT, an ISA-level model predicts every fetch address,
// enable pulse, writeback and flag, and literal checks pin the results.
module tb_reg_file_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       valid_en;
  logic [7:0] pc;
  logic       zero_flag;
  logic       halted;
  logic       illegal_op;

  reg_file_sequencer_if bus ();

  reg_file_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .bus        (bus),
    .pc         (pc),
    .zero_flag  (zero_flag),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] imem [0:255];
  logic [15:0] rf [0:3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [17:0] wr_log [$];
  logic [7:0]  fetch_log [$];
  logic [7:0]  exp_fetch [0:6] = '{8'h00, 8'h20, 8'h21, 8'h22, 8'hFF, 8'h00, 8'h01};

  assign bus.instr_valid = valid_en;
  assign bus.instr_data  = imem[bus.instr_addr];

  // Register file: read data appears the cycle after read_en
  always @(posedge clk) begin
    if (bus.read_en) begin
      bus.read_data1 <= rf[bus.read_adr1];
      bus.read_data2 <= rf[bus.read_adr2];
    end
    if (bus.write_en) begin
      rf[bus.write_adr] <= bus.write_data;
      wr_log.push_back({bus.write_adr, bus.write_data});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] s1, input logic [1:0] s2);
    return {op, rd, s1, s2, 6'b000000};
  endfunction

  function automatic logic [15:0] ri(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] s1, input logic [7:0] imm);
    return {op, rd, s1, imm};
  endfunction

  // ---------------- ISA-level reference model ----------------
  logic [15:0] m_regs [0:3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [7:0]  m_pc;
  logic        m_zero, m_illegal, m_halt;
  logic [15:0] m_ir;
  logic        p_wr;
  logic [1:0]  p_adr;
  logic [15:0] p_data;
  int          m_lat;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          acc_valid = 1'b0;
  bit          stalled = 1'b0;

  task automatic model_exec(input logic [15:0] ins);
    logic [3:0]  op;
    logic [15:0] a, b, res;
    logic [7:0]  imm, nxt;
    logic        wr;
    op  = ins[15:12];
    imm = ins[7:0];
    a   = m_regs[ins[9:8]];
    b   = m_regs[ins[7:6]];
    res = 16'h0000;
    wr  = 1'b0;
    nxt = m_pc + 8'd1;
    m_ir = ins;
    if (op >= 4'h1 && op <= 4'h7) begin
      wr = 1'b1;
      case (op)
        4'h1: res = a + b;
        4'h2: res = a - b;
        4'h3: res = a & b;
        4'h4: res = a | b;
        4'h5: res = a ^ b;
        4'h6: res = {8'h00, imm};
        default: res = a;
      endcase
    end else if (op == 4'h8) begin
      nxt = imm;
    end else if (op == 4'h9) begin
      if (a == 16'h0000) nxt = imm;
    end else if (op == 4'hF) begin
      m_halt = 1'b1;
      nxt    = m_pc;
    end else if (op >= 4'hA) begin
      m_illegal = 1'b1;
    end
    if (wr) begin
      m_zero = (res == 16'h0000);
      p_wr   = 1'b1;
      p_adr  = ins[11:10];
      p_data = res;
    end
    m_lat = wr ? 4 : 3;
    m_pc  = nxt;
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin : compare
    int   since;
    logic e_rd, e_wr, e_req, e_halt;
    cyc++;
    if (!reset) begin
      m_pc = 8'h00; m_zero = 1'b0; m_illegal = 1'b0; m_halt = 1'b0;
      acc_valid = 1'b0; p_wr = 1'b0; stalled = 1'b0;
    end else begin
      since  = cyc - acc_cyc;
      e_rd   = acc_valid && since == 1;
      e_wr   = acc_valid && p_wr && since == 3;
      e_halt = acc_valid && m_halt && since >= 3;
      if (!acc_valid)          e_req = run;
      else if (m_halt)         e_req = 1'b0;
      else if (since >= m_lat) e_req = run;
      else                     e_req = 1'b0;
      check("rw_exclusive", bus.read_en & bus.write_en, 1'b0);
      check("read_en", bus.read_en, e_rd);
      check("write_en", bus.write_en, e_wr);
      check("halted", halted, e_halt);
      check("instr_req", bus.instr_req, e_req);
      if (e_rd && bus.read_en) begin
        check("read_adr1", bus.read_adr1, m_ir[9:8]);
        check("read_adr2", bus.read_adr2, m_ir[7:6]);
      end
      if (e_wr && bus.write_en) begin
        check("write_adr", bus.write_adr, p_adr);
        check("write_data", bus.write_data, p_data);
        m_regs[p_adr] = p_data;
        p_wr = 1'b0;
      end
      if (e_halt) begin
        check("halt_pc", pc, m_pc);
        check("halt_zero", zero_flag, m_zero);
        check("halt_illegal", illegal_op, m_illegal);
      end
      if (!run || !valid_en) stalled = 1'b1;
      if (bus.instr_req) begin
        check("instr_addr", bus.instr_addr, m_pc);
        check("fetch_pc", pc, m_pc);
      end
      if (bus.instr_req && bus.instr_valid) begin
        check("zero_at_fetch", zero_flag, m_zero);
        check("illegal_at_fetch", illegal_op, m_illegal);
        if (acc_valid && !stalled) check("latency", since, m_lat);
        fetch_log.push_back(bus.instr_addr);
        model_exec(bus.instr_data);
        acc_cyc   = cyc;
        acc_valid = 1'b1;
        stalled   = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic enter_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_imem();
    wr_log.delete();
    fetch_log.delete();
  endtask

  task automatic wait_halted(input int max_cycles);
    int k;
    k = 0;
    while (!halted && k < max_cycles) begin
      step(1);
      k++;
    end
    check("halt_reached", halted, 1'b1);
  endtask

  initial begin
    reset    = 1'b0;
    run      = 1'b0;
    valid_en = 1'b1;
    clear_imem();
    step(2);
    run = 1'b1;
    #1;
    check("rst_instr_req", bus.instr_req, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_read_en", bus.read_en, 1'b0);
    check("rst_write_en", bus.write_en, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_zero", zero_flag, 1'b0);
    check("rst_illegal", illegal_op, 1'b0);

    // LDI / ADD chain
    imem[0] = ri(4'h6, 2'd1, 2'd0, 8'h05);
    imem[1] = ri(4'h6, 2'd2, 2'd0, 8'h0A);
    imem[2] = rr(4'h1, 2'd3, 2'd1, 2'd2);
    step(1);
    reset = 1'b1;
    #1;
    check("first_instr_req", bus.instr_req, 1'b1);
    check("first_instr_addr", bus.instr_addr, 8'h00);
    wait_halted(100);
    check("add_pc", pc, 8'h03);
    check("add_zero", zero_flag, 1'b0);
    check("add_rf3", rf[3], 16'h000F);
    check("add_model_r3", m_regs[3], 16'h000F);
    check("add_nwrites", wr_log.size(), 3);
    check("add_wb", wr_log[2], {2'd3, 16'h000F});

    // SUB wrap and zero flag
    enter_reset();
    imem[0] = ri(4'h6, 2'd1, 2'd0, 8'h00);
    imem[1] = ri(4'h6, 2'd2, 2'd0, 8'h01);
    imem[2] = rr(4'h2, 2'd0, 2'd1, 2'd2);
    imem[3] = rr(4'h2, 2'd0, 2'd2, 2'd2);
    step(1);
    reset = 1'b1;
    wait_halted(100);
    check("sub_wrap_wb", wr_log[2], {2'd0, 16'hFFFF});
    check("sub_zero_wb", wr_log[3], {2'd0, 16'h0000});
    check("sub_zero_flag", zero_flag, 1'b1);
    check("sub_pc", pc, 8'h04);

    // Branches: taken BEQZ, untaken BEQZ, JMP to 0xFF, NOP wraps the PC
    enter_reset();
    imem[8'h00] = ri(4'h9, 2'd0, 2'd0, 8'h20);
    imem[8'h20] = ri(4'h6, 2'd0, 2'd0, 8'h01);
    imem[8'h21] = ri(4'h9, 2'd0, 2'd0, 8'h40);
    imem[8'h22] = ri(4'h8, 2'd0, 2'd0, 8'hFF);
    imem[8'hFF] = 16'h0000;
    step(1);
    reset = 1'b1;
    wait_halted(100);
    check("br_nfetch", fetch_log.size(), 7);
    for (int i = 0; i < 7; i++) check("br_fetch_addr", fetch_log[i], exp_fetch[i]);
    check("br_nwrites", wr_log.size(), 1);
    check("br_pc", pc, 8'h01);
    check("br_rf0", rf[0], 16'h0001);

    // Handshake stalls: no valid for 5 cycles, then run low with valid high
    enter_reset();
    valid_en = 1'b0;
    imem[0] = ri(4'h6, 2'd1, 2'd0, 8'h33);
    imem[1] = rr(4'h7, 2'd2, 2'd1, 2'd0);
    imem[2] = rr(4'h5, 2'd3, 2'd1, 2'd2);
    step(1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("stall_req", bus.instr_req, 1'b1);
      check("stall_pc", pc, 8'h00);
      check("stall_rd", bus.read_en, 1'b0);
      check("stall_wr", bus.write_en, 1'b0);
    end
    run      = 1'b0;
    valid_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("norun_req", bus.instr_req, 1'b0);
      check("norun_pc", pc, 8'h00);
      check("norun_rd", bus.read_en, 1'b0);
      check("norun_wr", bus.write_en, 1'b0);
    end
    run = 1'b1;
    wait_halted(100);
    check("stall_end_pc", pc, 8'h03);
    check("mov_rf2", rf[2], 16'h0033);
    check("xor_rf3", rf[3], 16'h0000);
    check("xor_zero", zero_flag, 1'b1);

    // Illegal opcode then HALT
    enter_reset();
    imem[0] = 16'hB000;
    imem[1] = ri(4'h6, 2'd1, 2'd0, 8'h77);
    step(1);
    reset = 1'b1;
    wait_halted(100);
    check("ill_flag", illegal_op, 1'b1);
    check("ill_pc", pc, 8'h02);
    check("ill_rf1", rf[1], 16'h0077);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("halt_req", bus.instr_req, 1'b0);
      check("halt_stays", halted, 1'b1);
    end

    // Reset during WRITEBACK drops the write and restarts at pc 0
    enter_reset();
    imem[0] = ri(4'h6, 2'd2, 2'd0, 8'h99);
    step(1);
    reset = 1'b1;
    for (int k = 0; k < 10 && !bus.write_en; k++) step(1);
    check("wb_reached", bus.write_en, 1'b1);
    reset = 1'b0;
    run   = 1'b0;
    #1;
    check("abort_write_en", bus.write_en, 1'b0);
    check("abort_pc", pc, 8'h00);
    check("abort_illegal", illegal_op, 1'b0);
    check("abort_halted", halted, 1'b0);
    step(1);
    reset = 1'b1;
    #1;
    check("abort_dropped", rf[2], 16'h0033);
    check("abort_norun_req", bus.instr_req, 1'b0);
    run = 1'b1;
    #1;
    check("restart_req", bus.instr_req, 1'b1);
    check("restart_addr", bus.instr_addr, 8'h00);
    wait_halted(100);
    check("restart_rf2", rf[2], 16'h0099);
    check("restart_pc", pc, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
